// File: rtl/dcfifo_arb_pkg.sv
// rtl/dcfifo_arb_pkg.sv - shared types and helpers for the dcfifo read arbiter
package dcfifo_arb_pkg;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  function automatic int burst_cnt_w(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/dcfifo_rr_pick.sv
// rtl/dcfifo_rr_pick.sv - combinational round-robin picker
// Finds the first set request strictly after last, wrapping modulo NUM_CH.
module dcfifo_rr_pick #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   last,
  output logic              found,
  output logic [CH_W-1:0]   idx
);

  logic [2*NUM_CH-1:0] dbl;
  logic [2*NUM_CH-1:0] mask;
  logic [2*NUM_CH-1:0] cand;

  // Doubled vector lets a plain lowest-set-bit search handle the wrap.
  always_comb begin
    dbl  = {req, req};
    mask = '0;
    for (int j = 0; j < 2*NUM_CH; j++) begin
      mask[j] = (j > int'(last)) && (j <= int'(last) + NUM_CH);
    end
    cand  = dbl & mask;
    found = 1'b0;
    idx   = '0;
    for (int j = 2*NUM_CH-1; j >= 0; j--) begin
      if (cand[j]) begin
        found = 1'b1;
        idx   = CH_W'(j % NUM_CH);
      end
    end
  end

endmodule

// File: rtl/dcfifo_rd_arbiter.sv
// rtl/dcfifo_rd_arbiter.sv - round-robin burst arbiter draining show-ahead dcfifos
// One registered output stream tagged with the source channel.
module dcfifo_rd_arbiter
  import dcfifo_arb_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int WIDTH     = 20,
  parameter int CH_W      = $clog2(NUM_CH),
  parameter int MAX_BURST = 4
) (
  input  logic                    aclr,
  input  logic                    rdclk,
  input  logic [NUM_CH-1:0]       ch_enable,
  input  logic [NUM_CH-1:0]       ch_empty,
  input  logic [NUM_CH*WIDTH-1:0] ch_q,
  output logic [NUM_CH-1:0]       ch_rdreq,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [CH_W-1:0]         out_ch,
  input  logic                    out_ready,
  output logic                    busy
);

  localparam int              BCW       = burst_cnt_w(MAX_BURST);
  localparam logic [BCW-1:0]  LAST_BEAT = BCW'(MAX_BURST - 1);
  localparam logic [CH_W-1:0] LAST_CH   = CH_W'(NUM_CH - 1);

  arb_state_t      state, state_n;
  logic [CH_W-1:0] g, g_n;
  logic [CH_W-1:0] last_grant, last_n;
  logic [BCW-1:0]  burst_cnt, burst_n;

  logic             load;
  logic             g_empty;
  logic             g_en;
  logic             xfer;
  logic [WIDTH-1:0] g_q;
  logic             pick_found;
  logic [CH_W-1:0]  pick_idx;

  dcfifo_rr_pick #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_pick (
    .req   (ch_enable & ~ch_empty),
    .last  (last_grant),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign load    = !out_valid || out_ready;
  assign g_empty = ch_empty[g];
  assign g_en    = ch_enable[g];
  assign g_q     = ch_q[g*WIDTH +: WIDTH];
  assign xfer    = (state == GRANT) && load && !g_empty && g_en;
  assign busy    = (state == GRANT);

  always_comb begin
    state_n     = state;
    g_n         = g;
    last_n      = last_grant;
    burst_n     = burst_cnt;
    ch_rdreq    = '0;
    ch_rdreq[g] = xfer;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_n = GRANT;
          g_n     = pick_idx;
          last_n  = pick_idx;
          burst_n = '0;
        end
      end
      GRANT: begin
        if (xfer) begin
          burst_n = burst_cnt + 1'b1;
        end
        // Empty flag lags a pop by one edge, so a one-word FIFO exits here next cycle.
        if ((xfer && burst_cnt == LAST_BEAT) || g_empty || !g_en) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge rdclk or posedge aclr) begin
    if (aclr) begin
      state      <= IDLE;
      g          <= '0;
      last_grant <= LAST_CH;
      burst_cnt  <= '0;
      out_valid  <= 1'b0;
      out_ch     <= '0;
    end else begin
      state      <= state_n;
      g          <= g_n;
      last_grant <= last_n;
      burst_cnt  <= burst_n;
      if (load) begin
        out_valid <= xfer;
        if (xfer) begin
          out_ch <= g;
        end
      end
    end
  end

  always_ff @(posedge rdclk) begin
    if (xfer) begin
      out_data <= g_q;
    end
  end

endmodule

// File: tb/tb_dcfifo_rd_arbiter.sv
// tb/tb_dcfifo_rd_arbiter.sv - directed scoreboard bench for dcfifo_rd_arbiter
module tb_dcfifo_rd_arbiter;

  localparam int NUM_CH    = 4;
  localparam int WIDTH     = 20;
  localparam int CH_W      = 2;
  localparam int MAX_BURST = 4;
  localparam int DEPTH     = 64;

  logic                    aclr;
  logic                    rdclk;
  logic [NUM_CH-1:0]       ch_enable;
  logic [NUM_CH-1:0]       ch_empty;
  logic [NUM_CH*WIDTH-1:0] ch_q;
  logic [NUM_CH-1:0]       ch_rdreq;
  logic                    out_valid;
  logic [WIDTH-1:0]        out_data;
  logic [CH_W-1:0]         out_ch;
  logic                    out_ready;
  logic                    busy;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] mem [NUM_CH][DEPTH];
  int               wr_ptr [NUM_CH];
  int               rd_ptr [NUM_CH];
  int               base   [NUM_CH];

  logic [WIDTH-1:0] exp_q [NUM_CH][$];
  int               obs_ch[$];
  int               exp_seq[$];

  logic             bp_en;
  logic [3:0]       pat;
  int               ph;
  logic             stalled_prev;
  logic [WIDTH-1:0] data_prev;
  logic [CH_W-1:0]  ch_prev;
  logic [WIDTH-1:0] exp_w;

  dcfifo_rd_arbiter #(
    .NUM_CH    (NUM_CH),
    .WIDTH     (WIDTH),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .aclr      (aclr),
    .rdclk     (rdclk),
    .ch_enable (ch_enable),
    .ch_empty  (ch_empty),
    .ch_q      (ch_q),
    .ch_rdreq  (ch_rdreq),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial begin
    rdclk = 1'b0;
    forever #5 rdclk = ~rdclk;
  end

  // Show-ahead FIFO model: empty flag and head follow the pop one edge later.
  always @(posedge rdclk or posedge aclr) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (aclr) rd_ptr[i] <= wr_ptr[i];
      else if (ch_rdreq[i]) rd_ptr[i] <= rd_ptr[i] + 1;
    end
  end

  always_comb begin
    ch_empty = '0;
    ch_q     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_empty[i]              = (rd_ptr[i] == wr_ptr[i]);
      ch_q[i*WIDTH +: WIDTH]   = mem[i][rd_ptr[i] % DEPTH];
    end
  end

  initial begin
    out_ready = 1'b1;
    ph        = 0;
    pat       = 4'b1001;
    forever begin
      @(posedge rdclk);
      #1;
      out_ready = bp_en ? pat[ph % 4] : 1'b1;
      ph++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge rdclk) begin
    if (!aclr) begin
      chk("rdreq_legal", 32'(ch_rdreq & (ch_empty | ~ch_enable)), 32'd0);
      chk("rdreq_onehot", 32'($onehot0(ch_rdreq)), 32'd1);
      if (out_valid && !out_ready) chk("rdreq_stall", 32'(ch_rdreq), 32'd0);
      if (stalled_prev) begin
        chk("stall_data", 32'(out_data), 32'(data_prev));
        chk("stall_ch", 32'(out_ch), 32'(ch_prev));
      end
      if (out_valid && out_ready) begin
        total++;
        assert (exp_q[out_ch].size() != 0) else begin
          bad++;
          $error("FAIL extra_word observed=ch%0d:%0h expected=none", out_ch, out_data);
        end
        if (exp_q[out_ch].size() != 0) begin
          exp_w = exp_q[out_ch].pop_front();
          chk("data", 32'(out_data), 32'(exp_w));
          obs_ch.push_back(int'(out_ch));
        end
      end
      stalled_prev = out_valid && !out_ready;
      data_prev    = out_data;
      ch_prev      = out_ch;
    end else begin
      stalled_prev = 1'b0;
    end
  end

  task automatic push(input int c, input logic [WIDTH-1:0] d);
    mem[c][wr_ptr[c] % DEPTH] = d;
    wr_ptr[c]++;
    exp_q[c].push_back(d);
  endtask

  task automatic do_reset();
    @(posedge rdclk);
    #1;
    aclr = 1'b1;
    for (int i = 0; i < NUM_CH; i++) exp_q[i].delete();
    @(posedge rdclk);
    #1;
    aclr = 1'b0;
    obs_ch.delete();
    exp_seq.delete();
    for (int i = 0; i < NUM_CH; i++) base[i] = rd_ptr[i];
  endtask

  task automatic drain(input string tag);
    int n;
    int pend;
    n = 0;
    pend = 1;
    while (pend != 0 && n < 2000) begin
      @(negedge rdclk);
      n++;
      pend = (out_valid || busy) ? 1 : 0;
      for (int i = 0; i < NUM_CH; i++) if (exp_q[i].size() != 0) pend = 1;
    end
    chk({tag, "_drain_timeout"}, 32'(pend), 32'd0);
    repeat (3) @(posedge rdclk);
    #1;
  endtask

  task automatic build_rr(input int n_each);
    int rem [NUM_CH];
    int left;
    int take;
    for (int i = 0; i < NUM_CH; i++) rem[i] = n_each;
    left = n_each * NUM_CH;
    exp_seq.delete();
    while (left > 0) begin
      for (int c = 0; c < NUM_CH; c++) begin
        take = (rem[c] < MAX_BURST) ? rem[c] : MAX_BURST;
        for (int k = 0; k < take; k++) exp_seq.push_back(c);
        rem[c] -= take;
        left   -= take;
      end
    end
  endtask

  task automatic cmp_seq(input string tag);
    chk({tag, "_len"}, 32'(obs_ch.size()), 32'(exp_seq.size()));
    for (int i = 0; i < obs_ch.size() && i < exp_seq.size(); i++) begin
      chk({tag, "_ch"}, 32'(obs_ch[i]), 32'(exp_seq[i]));
    end
  endtask

  task automatic chk_pops(input string tag, input int c, input int n);
    chk(tag, 32'(rd_ptr[c] - base[c]), 32'(n));
  endtask

  task automatic rr_run(input string tag, input logic bp, input int off);
    do_reset();
    bp_en = bp;
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < NUM_CH; c++) push(c, WIDTH'(off + c*256 + k));
    end
    build_rr(10);
    drain(tag);
    cmp_seq(tag);
    for (int c = 0; c < NUM_CH; c++) chk_pops({tag, "_pops"}, c, 10);
    bp_en = 1'b0;
  endtask

  initial begin
    int n;
    aclr         = 1'b1;
    ch_enable    = '1;
    bp_en        = 1'b0;
    stalled_prev = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_ptr[i] = 0;
      base[i]   = 0;
    end

    repeat (2) @(negedge rdclk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_ch", 32'(out_ch), 32'd0);
    chk("rst_rdreq", 32'(ch_rdreq), 32'd0);

    // Single channel with latency check.
    do_reset();
    push(2, 20'hA1);
    push(2, 20'hA2);
    push(2, 20'hA3);
    @(negedge rdclk);
    chk("lat_idle_busy", 32'(busy), 32'd0);
    @(negedge rdclk);
    chk("lat_grant_busy", 32'(busy), 32'd1);
    chk("lat_grant_rdreq", 32'(ch_rdreq), 32'b0100);
    @(negedge rdclk);
    chk("lat_out_valid", 32'(out_valid), 32'd1);
    chk("lat_out_data", 32'(out_data), 32'hA1);
    chk("lat_out_ch", 32'(out_ch), 32'd2);
    drain("single");
    exp_seq = '{2, 2, 2};
    cmp_seq("single");
    chk_pops("single_pops", 2, 3);

    rr_run("rr", 1'b0, 20'h10000);
    rr_run("bp", 1'b1, 20'h20000);

    // Disable channel 1 after its second word.
    do_reset();
    for (int k = 0; k < 6; k++) push(1, WIDTH'(20'h40100 + k));
    push(2, 20'h40200);
    push(2, 20'h40201);
    n = 0;
    while ((rd_ptr[1] - base[1]) < 2 && n < 100) begin
      @(posedge rdclk);
      #1;
      n++;
    end
    ch_enable[1] = 1'b0;
    repeat (10) @(posedge rdclk);
    #1;
    chk_pops("dis_pops_stopped", 1, 2);
    chk_pops("dis_pops_ch2", 2, 2);
    ch_enable[1] = 1'b1;
    drain("dis");
    exp_seq = '{1, 1, 2, 2, 1, 1, 1, 1};
    cmp_seq("dis");
    chk_pops("dis_pops_resumed", 1, 6);

    // One-word channel next to a two-word channel.
    do_reset();
    push(3, 20'h50300);
    push(0, 20'h50000);
    push(0, 20'h50001);
    drain("race");
    exp_seq = '{0, 0, 3};
    cmp_seq("race");
    chk_pops("race_pops_ch3", 3, 1);
    chk_pops("race_pops_ch0", 0, 2);

    // Reset in the middle of a channel 1 burst.
    do_reset();
    for (int k = 0; k < 8; k++) push(1, WIDTH'(20'h60100 + k));
    n = 0;
    while ((rd_ptr[1] - base[1]) < 2 && n < 100) begin
      @(posedge rdclk);
      #1;
      n++;
    end
    chk("mid_busy_before", 32'(busy), 32'd1);
    aclr = 1'b1;
    for (int i = 0; i < NUM_CH; i++) exp_q[i].delete();
    #1;
    chk("mid_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rdreq", 32'(ch_rdreq), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    @(posedge rdclk);
    #1;
    aclr = 1'b0;
    obs_ch.delete();
    for (int i = 0; i < NUM_CH; i++) base[i] = rd_ptr[i];
    push(0, 20'h70000);
    push(0, 20'h70001);
    push(1, 20'h70100);
    push(1, 20'h70101);
    drain("post_rst");
    exp_seq = '{0, 0, 1, 1};
    cmp_seq("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
